// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants for the BT.601 full-range YCbCr-to-RGB converter.
// Coefficients are Q10, i.e. round(c * 2^10).
package ycbcr2rgb_pkg;

    localparam int FRAC_BITS_DEF = 10;

    localparam int K_R_CR = 1436;
    localparam int K_G_CB = 352;
    localparam int K_G_CR = 731;
    localparam int K_B_CB = 1815;

    localparam int OFFSET  = 128;
    localparam int LATENCY = 4;

    localparam int PROD_W = 21;
    localparam int SUM_W  = 22;

    // Clamp an already-descaled channel value into 0..255.
    function automatic logic [7:0] sat8(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1])
            return 8'd0;
        else if (v > SUM_W'(255))
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Clock-enabled shift register that keeps timing signals aligned with the pixel pipeline.
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                taps[i] <= '0;
        end else if (ce) begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/ycbcr2rgb.sv
// Four-stage pipelined full-range BT.601 YCbCr-to-RGB converter with aligned sync/DE.
// Stages: chroma offset, coefficient multiply, rounded sum, descale + saturate.
module ycbcr2rgb
    import ycbcr2rgb_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] Y,
    input  logic [7:0] Cb,
    input  logic [7:0] Cr,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_de,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_de
);

    localparam logic signed [SUM_W-1:0] BIAS = SUM_W'(1) << (FRAC_BITS - 1);

    logic        [7:0]        y1;
    logic signed [8:0]        dcb1, dcr1;

    logic        [7:0]        y2;
    logic signed [PROD_W-1:0] prod_rcr, prod_gcb, prod_gcr, prod_bcb;

    logic signed [SUM_W-1:0]  y_scaled;
    logic signed [SUM_W-1:0]  sum_r, sum_g, sum_b;

    assign y_scaled = SUM_W'(y2) << FRAC_BITS;

    // A zeroed pipeline descales to 0 on every channel, so reset never leaks stale pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            y1       <= '0;
            dcb1     <= '0;
            dcr1     <= '0;
            y2       <= '0;
            prod_rcr <= '0;
            prod_gcb <= '0;
            prod_gcr <= '0;
            prod_bcb <= '0;
            sum_r    <= '0;
            sum_g    <= '0;
            sum_b    <= '0;
            R        <= '0;
            G        <= '0;
            B        <= '0;
        end else if (ce) begin
            y1   <= Y;
            dcb1 <= $signed({1'b0, Cb}) - 9'(OFFSET);
            dcr1 <= $signed({1'b0, Cr}) - 9'(OFFSET);

            y2       <= y1;
            prod_rcr <= PROD_W'(K_R_CR) * PROD_W'(dcr1);
            prod_gcb <= PROD_W'(K_G_CB) * PROD_W'(dcb1);
            prod_gcr <= PROD_W'(K_G_CR) * PROD_W'(dcr1);
            prod_bcb <= PROD_W'(K_B_CB) * PROD_W'(dcb1);

            // Half-LSB bias turns the later floor-shift into round-to-nearest.
            sum_r <= y_scaled + SUM_W'(prod_rcr) + BIAS;
            sum_g <= y_scaled - SUM_W'(prod_gcb) - SUM_W'(prod_gcr) + BIAS;
            sum_b <= y_scaled + SUM_W'(prod_bcb) + BIAS;

            R <= sat8(sum_r >>> FRAC_BITS);
            G <= sat8(sum_g >>> FRAC_BITS);
            B <= sat8(sum_b >>> FRAC_BITS);
        end
    end

    sync_delay #(
        .WIDTH (3),
        .DEPTH (LATENCY)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   ({in_hsync, in_vsync, in_de}),
        .q   ({out_hsync, out_vsync, out_de})
    );

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Randomised self-checking bench for ycbcr2rgb against a queue-based reference of
// the BT.601 equations, plus directed grey-ramp, saturation, frame, ce and reset runs.
module tb_ycbcr2rgb;

    logic       clk = 1'b0;
    logic       rst, ce;
    logic [7:0] Y, Cb, Cr;
    logic       in_hsync, in_vsync, in_de;
    logic [7:0] R, G, B;
    logic       out_hsync, out_vsync, out_de;

    always #5 clk = ~clk;

    ycbcr2rgb dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .Y         (Y),
        .Cb        (Cb),
        .Cr        (Cr),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_de     (in_de),
        .R         (R),
        .G         (G),
        .B         (B),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_de    (out_de)
    );

    typedef struct packed {
        logic [7:0] r, g, b;
        logic [2:0] sync;
    } pix_t;

    // Samples accepted but not yet visible; the output shows the sample from 4 enabled edges ago.
    localparam int IN_FLIGHT = 3;

    pix_t  pend_q[$];
    pix_t  cur_exp;
    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    function automatic logic [7:0] clampChan(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic pix_t refPixel(input int y, input int cb, input int cr, input logic [2:0] sync);
        pix_t p;
        int   dcb = cb - 128;
        int   dcr = cr - 128;
        p.r    = clampChan((y * 1024 + 1436 * dcr + 512) / 1024);
        p.g    = clampChan((y * 1024 - 352 * dcb - 731 * dcr + 512) / 1024);
        p.b    = clampChan((y * 1024 + 1815 * dcb + 512) / 1024);
        p.sync = sync;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%0d want=%0d", phase, tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                                 input logic [2:0] sync, input logic ce_v, input logic rst_v);
        Y  = y;  Cb = cb;  Cr = cr;
        {in_hsync, in_vsync, in_de} = sync;
        ce  = ce_v;
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            pend_q.delete();
            repeat (IN_FLIGHT) pend_q.push_back('0);
            cur_exp = '0;
        end else if (ce_v) begin
            cur_exp = pend_q.pop_front();
            pend_q.push_back(refPixel(y, cb, cr, sync));
        end
        #1;
        checkOutput("R", R, cur_exp.r);
        checkOutput("G", G, cur_exp.g);
        checkOutput("B", B, cur_exp.b);
        checkOutput("sync", {out_hsync, out_vsync, out_de}, cur_exp.sync);
    endtask

    task automatic randomCycle(input logic ce_v, input logic rst_v);
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), ce_v, rst_v);
    endtask

    logic [7:0] dv_y  [4] = '{76, 255, 0, 128};
    logic [7:0] dv_cb [4] = '{85, 128, 128, 0};
    logic [7:0] dv_cr [4] = '{255, 128, 255, 255};
    logic [7:0] dv_r  [4] = '{254, 255, 178, 255};
    logic [7:0] dv_g  [4] = '{0, 255, 0, 81};
    logic [7:0] dv_b  [4] = '{0, 255, 0, 0};

    initial begin
        rst = 1'b1; ce = 1'b0;
        Y = '0; Cb = '0; Cr = '0;
        in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;

        phase = "reset";
        applyStimulus(8'd0, 8'd0, 8'd0, 3'b000, 1'b0, 1'b1);
        applyStimulus(8'd9, 8'd9, 8'd9, 3'b111, 1'b1, 1'b1);

        phase = "grey";
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(i), 8'd128, 8'd128, 3'b001, 1'b1, 1'b0);
            if (i >= 3) begin
                checkOutput("lat_R", R, i - 3);
                checkOutput("lat_B", B, i - 3);
            end
        end
        repeat (3) applyStimulus(8'd0, 8'd128, 8'd128, 3'b000, 1'b1, 1'b0);

        phase = "extremes";
        for (int v = 0; v < 4; v++) begin
            applyStimulus(dv_y[v], dv_cb[v], dv_cr[v], 3'b001, 1'b1, 1'b0);
            repeat (3) applyStimulus(8'd0, 8'd128, 8'd128, 3'b000, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_R", v), R, dv_r[v]);
            checkOutput($sformatf("vec%0d_G", v), G, dv_g[v]);
            checkOutput($sformatf("vec%0d_B", v), B, dv_b[v]);
        end

        phase = "frame";
        for (int line = 0; line < 3; line++) begin
            for (int x = 0; x < 12; x++) begin
                logic hs, vs, de;
                hs = (x == 1) || (x == 2);
                vs = (line == 0);
                de = (x >= 4);
                applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), {hs, vs, de}, 1'b1, 1'b0);
            end
        end

        phase = "ce_gate";
        for (int k = 0; k < 40; k++) begin
            randomCycle(1'b1, 1'b0);
            randomCycle(1'b0, 1'b0);
            randomCycle(1'b0, 1'b0);
        end

        phase = "reset_mid";
        repeat (10) randomCycle(1'b1, 1'b0);
        applyStimulus(8'd200, 8'd60, 8'd200, 3'b001, 1'b0, 1'b1);
        checkOutput("rst_de", out_de, 1'b0);
        for (int k = 0; k < 30; k++)
            randomCycle(1'($urandom_range(0, 1)), 1'b0);

        phase = "random";
        for (int k = 0; k < 400; k++)
            randomCycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ycbcr2rgb.md
# ycbcr2rgb

Pipelined full-range BT.601 YCbCr-to-RGB converter. It is the inverse of `rgb2ycbcr` and sits on the HDMI path between YCbCr-domain processing (for example skin-colour segmentation) and `hdmi_out`. Sync and data-enable signals are delayed to stay aligned with the converted pixels.

## Interface
Parameters:
- FRAC_BITS, 10, fractional bits of the fixed-point coefficients. Coefficients are round(c·2^FRAC_BITS).

Ports:
- clk  in  1  pixel clock (rx_pclk domain)
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low, the whole pipeline holds
- Y, Cb, Cr  in  8 each  unsigned input pixel
- in_hsync, in_vsync, in_de  in  1 each  input timing
- R, G, B  out  8 each  unsigned output pixel, saturated
- out_hsync, out_vsync, out_de  out  1 each  timing, aligned with R/G/B

## Operation
- Equations (FRAC_BITS=10): kRCr=1436, kGCb=352, kGCr=731, kBCb=1815.
  - R = Y + 1.402·(Cr−128)
  - G = Y − 0.344136·(Cb−128) − 0.714136·(Cr−128)
  - B = Y + 1.772·(Cb−128)
- Stage 1: dCb = Cb−128 and dCr = Cr−128, each signed 9-bit (range −128..127). Register Y as well.
- Stage 2: signed products kRCr·dCr, kGCb·dCb, kGCr·dCr, kBCb·dCb, each 21-bit signed. Y is carried along.
- Stage 3: sums of (Y<<FRAC_BITS) + products + 2^(FRAC_BITS−1) (rounding bias), each 22-bit signed. Sign subtracted terms for G.
- Stage 4: arithmetic shift right by FRAC_BITS, then saturate: negative → 0, >255 → 255, else the low 8 bits.
- in_hsync, in_vsync and in_de pass through a 4-stage delay with the same ce and rst as the data.
- Pixel data is converted regardless of in_de. Downstream qualifies it with out_de.
- No handshake or backpressure. ce is the only flow control.

## Timing
- Latency is exactly 4 clk edges with ce=1. A sample applied at ce-edge n appears on the outputs after ce-edge n+3, i.e. it is valid during the cycle following the 4th enabled edge.
- ce=0: every register (data and sync) holds. Latency counts only enabled edges.
- Reset:
  - All pipeline registers and all outputs go to 0 on the first rising edge with rst=1: R=G=B=0, out_hsync=out_vsync=out_de=0.
  - rst has priority over ce.
- Reset mid-frame:
  - In-flight pixels are discarded.
  - Outputs read 0 with out_de low until the first post-reset sample has propagated 4 enabled edges.
  - No stale data may emerge after reset deasserts.
- Neutral chroma (Cb=Cr=128) must give R=G=B=Y exactly. The rounding bias must not bias it.
- Saturation applies independently per channel. Both over- and underflow can occur in one pixel.

## Structure
- Package `ycbcr2rgb_pkg`:
  - FRAC_BITS default
  - coefficient constants kRCr, kGCb, kGCr, kBCb
  - OFFSET=128
  - LATENCY=4
  - product and sum widths (21, 22)
- Sub-module `sync_delay`: parameterised WIDTH and DEPTH, with ce and synchronous rst. It is instantiated once with WIDTH=3, DEPTH=LATENCY for {hsync, vsync, de}.
- The conversion datapath stays inline in `ycbcr2rgb`.

## Test plan
- Grey ramp: Y=0..255 with Cb=Cr=128, ce=1 → R=G=B=Y, each appearing exactly 4 edges after input.
- Pure red: (Y,Cb,Cr)=(76,85,255) → (R,G,B)=(254,0,0). Extremes: (255,128,128)→(255,255,255) and (0,128,255)→(178,0,0). These check saturation at 0 and 255.
- Sync alignment:
  - Drive a short frame (in_de pulses, hsync/vsync toggles) through the bench.
  - out_* must be the input pattern shifted 4 cycles.
  - The pixel under out_de must match the pixel under in_de.
- ce gating: toggle ce in a 1-on/2-off pattern → output sequence identical to the ce=1 run. Outputs are frozen while ce=0.
- Reset mid-stream:
  - Assert rst for 1 cycle during active video with ce=0 → next edge all outputs 0 and out_de=0.
  - The first new pixel appears 4 enabled edges after deassertion.
- Round-trip: `hdmi_in` → `rgb2ycbcr` → `ycbcr2rgb` → `hdmi_out` on a test image → every channel within ±2 of the source. The frame timing must match with a total delay of rgb2ycbcr latency plus 4.
